vga_timing_rx: RTL
==================

Name: vga_timing_rx

Overview:
- Receive-side counterpart of the VGA timing driver.
- Samples vga_hsync, vga_vsync and vga_rgb on the pixel clock and recovers line/frame timing from the sync edges.
- Checks the recovered timing against the configured video mode and, once locked, emits pixel coordinates plus a qualified pixel stream.
- Used as a loopback checker and as the front end for image-processing blocks fed by VGA-format video.

Parameters:
- H_SYNC, 96, hsync pulse width in pixel clocks
- H_BACK, 48, horizontal back porch
- H_ACTIVE, 640, active pixels per line
- H_TOTAL, 800, pixel clocks per line
- V_SYNC, 2, vsync pulse width in lines
- V_BACK, 33, vertical back porch in lines
- V_ACTIVE, 480, active lines per frame
- V_TOTAL, 525, lines per frame
- SYNC_POL, 0, active level of both syncs (0 = active-low)
- LOCK_FRAMES, 2, consecutive good frames required for lock

Ports:
- sclk  in  1  pixel clock (25 MHz)
- s_rst  in  1  reset
- vga_hsync  in  1  line sync from driver
- vga_vsync  in  1  frame sync from driver
- vga_rgb  in  16  RGB565 pixel
- pix_data  out  16  registered pixel
- pix_valid  out  1  pix_data is an active pixel and the block is locked
- pix_x  out  10  active column 0..H_ACTIVE-1
- pix_y  out  10  active row 0..V_ACTIVE-1
- frame_start  out  1  1-cycle pulse with pixel (0,0)
- locked  out  1  timing matches mode
- timing_err  out  1  1-cycle pulse on any timing mismatch

Interface: one clock; reset is synchronous and active-high. All logic runs on sclk. s_rst is sampled on sclk edges only.

Behaviour:
- **Input register.** Inputs pass through one register stage (hs_r, vs_r, rgb_r). A sync is "active" when it equals SYNC_POL.
- **Line start.** A line start is the cycle where hs_r first becomes active.
- **h_cnt (12 bit).** Loads 0 on line start, otherwise increments. It saturates at 4095; saturation counts as an error.
- **Line check.** At each line start, the previous h_cnt+1 is compared to H_TOTAL. This check is skipped for the first line after leaving SEARCH.
- **v_cnt (11 bit).** Updated only on line start:
  - loads 0 if vs_r is active now and was inactive at the previous line start;
  - otherwise increments.
  - At that reload, the previous v_cnt+1 is compared to V_TOTAL. This check is skipped for the first frame.
- **Active region.**
  - h_cnt in [H_SYNC+H_BACK, H_SYNC+H_BACK+H_ACTIVE), i.e. 144..783 for the default mode;
  - v_cnt in [V_SYNC+V_BACK, V_SYNC+V_BACK+V_ACTIVE), i.e. 35..514.
  - pix_x = h_cnt-(H_SYNC+H_BACK) and pix_y = v_cnt-(V_SYNC+V_BACK), both truncated to 10 bits.
- **Output latency.** Outputs are registered: a pixel presented on vga_rgb appears on pix_data 2 sclk later, aligned with its pix_valid, pix_x and pix_y.
- **FSM.**
  - SEARCH: wait for a vsync reload, then go to TRACK with good_cnt=0.
  - TRACK: each frame that completes with no line or frame error increments good_cnt. When good_cnt reaches LOCK_FRAMES, go to LOCKED.
  - LOCKED: locked=1.
  - Any error in TRACK or LOCKED: timing_err pulses 1 cycle, state goes to SEARCH, good_cnt clears.
  - An error and a vsync reload in the same cycle: the error wins; the state goes to SEARCH.
- **Gating.** pix_valid and frame_start are 0 unless the state is LOCKED. frame_start is pix_valid with pix_x=0 and pix_y=0.
- **Sync pulse widths.** Not checked; only periods are checked.
- **Reset.** When s_rst=1:
  - state SEARCH, counters 0;
  - pix_data 0, pix_valid 0, pix_x 0, pix_y 0, frame_start 0, locked 0, timing_err 0.
  - Reset mid-frame discards all progress. Lock needs a fresh vsync followed by LOCK_FRAMES good frames.

Optional Feature:
- Macro VGA_RX_CHECKSUM_EN.
- **When defined:**
  - adds outputs frame_sum (16 bit) and sum_valid (1 bit);
  - a 16-bit modulo-2^16 accumulator adds every pix_data with pix_valid=1, clearing on frame_start (which loads that frame's first pixel);
  - at the vsync reload that ends a LOCKED frame, frame_sum is loaded with the total and sum_valid pulses for 1 cycle;
  - reset clears frame_sum and sum_valid to 0.
- **When not defined:** the ports and logic are absent.

Test Plan:
- Reset, then ideal default-mode driver with rgb = 16'h1234 in the active area → locked rises after 3 vsyncs (1 to leave SEARCH, 2 good frames). Each subsequent frame then gives 307200 pix_valid cycles of data 16'h1234, plus one frame_start per frame.
- After lock, rgb = {6'b0, h_cnt[9:0]} of the driver → first pixel of each line has pix_data = 144 and pix_x = 0. The last pixel has pix_data = 783 and pix_x = 639, with 2-cycle latency.
- While locked, one line of 801 clocks → timing_err pulses once at the next line start, locked drops, and pix_valid stays 0 until relock 3 vsyncs later.
- Hsync stuck inactive for 4096 clocks → timing_err pulses and the state returns to SEARCH.
- s_rst asserted for 1 cycle mid-frame (line 200) → all outputs 0 the next cycle, and no pix_valid until relock.
- With VGA_RX_CHECKSUM_EN defined, constant pixel 16'h0001 → frame_sum = 307200 mod 65536 = 16'hB000 with a sum_valid pulse at each frame end.

Source files
------------

// File: rtl/vga_timing_rx.sv
// VGA timing receiver: recovers line/frame timing from the sync edges, checks it against the mode and
// emits coordinates plus a qualified pixel stream once locked. Define VGA_RX_CHECKSUM_EN for a per-frame pixel checksum.
module vga_timing_rx #(
  parameter int   H_SYNC      = 96,
  parameter int   H_BACK      = 48,
  parameter int   H_ACTIVE    = 640,
  parameter int   H_TOTAL     = 800,
  parameter int   V_SYNC      = 2,
  parameter int   V_BACK      = 33,
  parameter int   V_ACTIVE    = 480,
  parameter int   V_TOTAL     = 525,
  parameter logic SYNC_POL    = 1'b0,
  parameter int   LOCK_FRAMES = 2
) (
  input  logic        sclk,
  input  logic        s_rst,
  input  logic        vga_hsync,
  input  logic        vga_vsync,
  input  logic [15:0] vga_rgb,
  output logic [15:0] pix_data,
  output logic        pix_valid,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic        frame_start,
  output logic        locked,
  output logic        timing_err
`ifdef VGA_RX_CHECKSUM_EN
  ,
  output logic [15:0] frame_sum,
  output logic        sum_valid
`endif
);

  localparam logic [11:0] H_START = 12'(H_SYNC + H_BACK);
  localparam logic [11:0] H_END   = 12'(H_SYNC + H_BACK + H_ACTIVE);
  localparam logic [10:0] V_START = 11'(V_SYNC + V_BACK);
  localparam logic [10:0] V_END   = 11'(V_SYNC + V_BACK + V_ACTIVE);

  typedef enum logic [1:0] {SEARCH, TRACK, LOCKED} state_t;

  state_t      state_q, state_d;
  logic [7:0]  goodCnt_q, goodCnt_d;
  logic        lineChk_q, lineChk_d;

  logic        hsIn_q, vsIn_q;
  logic [15:0] rgbIn_q;
  logic        hsPrev_q, vsAtLine_q;
  logic [11:0] hCnt_q, hCnt_d;
  logic [10:0] vCnt_q, vCnt_d;

  logic [15:0] pixData_q;
  logic        pixValid_q, pixValid_d;
  logic [9:0]  pixX_q, pixX_d;
  logic [9:0]  pixY_q, pixY_d;
  logic        frameStart_q, frameStart_d;
  logic        locked_q;
  logic        timingErr_q, timingErr_d;

  logic hsActive, vsActive, lineStart, reload;
  logic satErr, lineErr, frameErr, anyErr;
  logic hInside, vInside;

  // Counters describe the pixel currently held in rgbIn_q, so outputs see it one edge later.
  always_comb begin
    hsActive  = (hsIn_q == SYNC_POL);
    vsActive  = (vsIn_q == SYNC_POL);
    lineStart = hsActive && !hsPrev_q;
    reload    = lineStart && vsActive && !vsAtLine_q;

    hCnt_d = hCnt_q;
    if (lineStart)
      hCnt_d = 12'd0;
    else if (hCnt_q != 12'hFFF)
      hCnt_d = hCnt_q + 12'd1;

    vCnt_d = vCnt_q;
    if (reload)
      vCnt_d = 11'd0;
    else if (lineStart && vCnt_q != 11'h7FF)
      vCnt_d = vCnt_q + 11'd1;

    satErr   = !lineStart && (hCnt_q == 12'd4094);
    lineErr  = lineStart && lineChk_q && ((hCnt_q + 12'd1) != 12'(H_TOTAL));
    frameErr = reload && ((vCnt_q + 11'd1) != 11'(V_TOTAL));
    anyErr   = satErr || lineErr || frameErr;
  end

  always_comb begin
    state_d     = state_q;
    goodCnt_d   = goodCnt_q;
    lineChk_d   = lineChk_q;
    timingErr_d = 1'b0;
    case (state_q)
      SEARCH: begin
        goodCnt_d = 8'd0;
        lineChk_d = 1'b0;
        if (reload)
          state_d = TRACK;
      end
      TRACK: begin
        if (anyErr) begin
          state_d     = SEARCH;
          goodCnt_d   = 8'd0;
          lineChk_d   = 1'b0;
          timingErr_d = 1'b1;
        end else begin
          if (lineStart)
            lineChk_d = 1'b1;
          if (reload) begin
            goodCnt_d = goodCnt_q + 8'd1;
            if ((goodCnt_q + 8'd1) >= 8'(LOCK_FRAMES))
              state_d = LOCKED;
          end
        end
      end
      LOCKED: begin
        if (anyErr) begin
          state_d     = SEARCH;
          goodCnt_d   = 8'd0;
          lineChk_d   = 1'b0;
          timingErr_d = 1'b1;
        end else if (lineStart) begin
          lineChk_d = 1'b1;
        end
      end
      default: begin
        state_d   = SEARCH;
        goodCnt_d = 8'd0;
        lineChk_d = 1'b0;
      end
    endcase
  end

  // Gating on the next state keeps the pixel of an error cycle from being qualified.
  always_comb begin
    hInside      = (hCnt_d >= H_START) && (hCnt_d < H_END);
    vInside      = (vCnt_d >= V_START) && (vCnt_d < V_END);
    pixValid_d   = (state_d == LOCKED) && hInside && vInside;
    pixX_d       = 10'(hCnt_d - H_START);
    pixY_d       = 10'(vCnt_d - V_START);
    frameStart_d = pixValid_d && (pixX_d == 10'd0) && (pixY_d == 10'd0);
  end

  always_ff @(posedge sclk) begin
    if (s_rst) begin
      hsIn_q       <= ~SYNC_POL;
      vsIn_q       <= ~SYNC_POL;
      rgbIn_q      <= 16'd0;
      hsPrev_q     <= 1'b0;
      vsAtLine_q   <= 1'b0;
      hCnt_q       <= 12'd0;
      vCnt_q       <= 11'd0;
      state_q      <= SEARCH;
      goodCnt_q    <= 8'd0;
      lineChk_q    <= 1'b0;
      pixData_q    <= 16'd0;
      pixValid_q   <= 1'b0;
      pixX_q       <= 10'd0;
      pixY_q       <= 10'd0;
      frameStart_q <= 1'b0;
      locked_q     <= 1'b0;
      timingErr_q  <= 1'b0;
    end else begin
      hsIn_q       <= vga_hsync;
      vsIn_q       <= vga_vsync;
      rgbIn_q      <= vga_rgb;
      hsPrev_q     <= hsActive;
      if (lineStart)
        vsAtLine_q <= vsActive;
      hCnt_q       <= hCnt_d;
      vCnt_q       <= vCnt_d;
      state_q      <= state_d;
      goodCnt_q    <= goodCnt_d;
      lineChk_q    <= lineChk_d;
      pixData_q    <= rgbIn_q;
      pixValid_q   <= pixValid_d;
      pixX_q       <= pixX_d;
      pixY_q       <= pixY_d;
      frameStart_q <= frameStart_d;
      locked_q     <= (state_d == LOCKED);
      timingErr_q  <= timingErr_d;
    end
  end

  assign pix_data    = pixData_q;
  assign pix_valid   = pixValid_q;
  assign pix_x       = pixX_q;
  assign pix_y       = pixY_q;
  assign frame_start = frameStart_q;
  assign locked      = locked_q;
  assign timing_err  = timingErr_q;

`ifdef VGA_RX_CHECKSUM_EN
  logic [15:0] sum_q;
  logic [15:0] frameSum_q;
  logic        sumValid_q;

  // The total is published only for a frame that stayed locked from its first to its last line.
  always_ff @(posedge sclk) begin
    if (s_rst) begin
      sum_q      <= 16'd0;
      frameSum_q <= 16'd0;
      sumValid_q <= 1'b0;
    end else begin
      sumValid_q <= 1'b0;
      if (pixValid_d)
        sum_q <= frameStart_d ? rgbIn_q : (sum_q + rgbIn_q);
      if (reload && (state_q == LOCKED) && !anyErr) begin
        frameSum_q <= sum_q;
        sumValid_q <= 1'b1;
      end
    end
  end

  assign frame_sum = frameSum_q;
  assign sum_valid = sumValid_q;
`endif

endmodule
